// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Channel state encoding, channel indices and the command priority order.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StHeld,
        StReleaseWait
    } chan_state_e;

    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned CH_RIGHT = 0;
    localparam int unsigned CH_LEFT  = 1;
    localparam int unsigned CH_DROP  = 2;

    // Highest priority first.
    localparam int unsigned PRIO_ORDER [NUM_CH] = '{CH_DROP, CH_LEFT, CH_RIGHT};

    function automatic logic [NUM_CH-1:0] arbitrate(input logic [NUM_CH-1:0] req);
        logic [NUM_CH-1:0] gnt;
        gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == '0 && req[PRIO_ORDER[i]]) begin
                gnt[PRIO_ORDER[i]] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned command outputs of the conditioner.
// slave: the conditioner itself; master: whatever drives the buttons and consumes commands.
interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic              btn_right_raw;
    logic              btn_left_raw;
    logic              btn_drop_raw;
    logic              move_right;
    logic              move_left;
    logic              drop_piece;
    logic [NUM_CH-1:0] btn_state;

    modport master (
        output btn_right_raw, btn_left_raw, btn_drop_raw,
        input  move_right, move_left, drop_piece, btn_state
    );

    modport slave (
        input  btn_right_raw, btn_left_raw, btn_drop_raw,
        output move_right, move_left, drop_piece, btn_state
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM and, when BUTTON_CONDITIONER_AUTO_REPEAT_EN
// is defined and REPEAT_EN is set, a held-time repeat counter.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 3750000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk_25MHz,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_event,
    output logic o_level
);

    localparam int unsigned   DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1))) begin : g_bad_cfg
        $error("debounce_channel: unsupported parameter set");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    chan_state_e            r_state, w_state_d;
    logic [DbW-1:0]         r_cnt, w_cnt_d;
    logic                   w_press;
    logic                   w_repeat;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_state <= StReleased;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_press   = 1'b0;
        case (r_state)
            StReleased: begin
                if (w_s) begin
                    w_state_d = StPressWait;
                    w_cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!w_s) begin
                    w_state_d = StReleased;
                    w_cnt_d   = '0;
                end else if (r_cnt == DbLast) begin
                    w_state_d = StHeld;
                    w_cnt_d   = '0;
                    w_press   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StHeld: begin
                if (!w_s) begin
                    w_state_d = StReleaseWait;
                    w_cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                if (w_s) begin
                    w_state_d = StHeld;
                    w_cnt_d   = '0;
                end else if (r_cnt == DbLast) begin
                    w_state_d = StReleased;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = StReleased;
                w_cnt_d   = '0;
            end
        endcase
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int unsigned RpMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
        localparam int unsigned RpW   = $clog2(RpMax + 1);

        logic [RpW-1:0] r_rpt, w_rpt_d, w_thr;
        logic           r_rpt_phase, w_rpt_phase_d;
        logic           w_fire;

        always_ff @(posedge clk_25MHz or negedge rst_n) begin
            if (!rst_n) begin
                r_rpt       <= '0;
                r_rpt_phase <= 1'b0;
            end else begin
                r_rpt       <= w_rpt_d;
                r_rpt_phase <= w_rpt_phase_d;
            end
        end

        // Phase 0 waits for the initial delay, phase 1 for each following period.
        always_comb begin
            w_rpt_d       = r_rpt;
            w_rpt_phase_d = r_rpt_phase;
            w_fire        = 1'b0;
            w_thr         = r_rpt_phase ? RpW'(REPEAT_PERIOD - 1) : RpW'(REPEAT_DELAY - 1);
            if (r_state == StHeld) begin
                if (w_s) begin
                    if (r_rpt == w_thr) begin
                        w_fire        = 1'b1;
                        w_rpt_d       = '0;
                        w_rpt_phase_d = 1'b1;
                    end else begin
                        w_rpt_d = r_rpt + 1'b1;
                    end
                end
            end else if (r_state != StReleaseWait) begin
                w_rpt_d       = '0;
                w_rpt_phase_d = 1'b0;
            end
        end

        assign w_repeat = w_fire;
    end else begin : g_no_repeat
        assign w_repeat = 1'b0;
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign o_event = w_press | w_repeat;
    assign o_level = (r_state == StHeld) || (r_state == StReleaseWait);

endmodule

// File: rtl/button_conditioner.sv
// Three debounced button channels feeding a drop > left > right pulse arbiter.
// Optional auto-repeat on left/right: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 3750000
) (
    input  logic                 clk_25MHz,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_event;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_pulse;

    assign w_raw[CH_RIGHT] = bus.btn_right_raw;
    assign w_raw[CH_LEFT]  = bus.btn_left_raw;
    assign w_raw[CH_DROP]  = bus.btn_drop_raw;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (bit'(ch != CH_DROP))
        ) u_chan (
            .clk_25MHz (clk_25MHz),
            .rst_n     (rst_n),
            .i_raw     (w_raw[ch]),
            .o_event   (w_event[ch]),
            .o_level   (w_level[ch])
        );
    end

    // A fresh event on an already pending channel simply merges into it.
    assign w_req   = r_pending | w_event;
    assign w_grant = arbitrate(w_req);

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_pulse   <= '0;
        end else begin
            r_pending <= w_req & ~w_grant;
            r_pulse   <= w_grant;
        end
    end

    assign bus.move_right = r_pulse[CH_RIGHT];
    assign bus.move_left  = r_pulse[CH_LEFT];
    assign bus.drop_piece = r_pulse[CH_DROP];
    assign bus.btn_state  = w_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner against a stability-rule reference model.
// Also exercises auto-repeat when BUTTON_CONDITIONER_AUTO_REPEAT_EN is defined.
module tb_button_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 20;
    localparam int unsigned RPER = 8;

    logic clk_25MHz = 1'b0;
    logic rst_n     = 1'b0;

    button_conditioner_if bus ();

    button_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // Reference model: a level change is accepted once the synchronised input has
    // disagreed with the accepted level for DEB+1 consecutive samples.
    bit       m_dl   [3][SYNC];
    bit       m_lvl  [3];
    int       m_run  [3];
    int       m_hold [3];
    bit [2:0] m_pend;
    bit [2:0] m_out;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < SYNC; i++) m_dl[c][i] = 1'b0;
            m_lvl[c]  = 1'b0;
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
        m_pend = '0;
        m_out  = '0;
    endtask

    task automatic model_edge(input logic [2:0] raw);
        bit [2:0] ev;
        bit [2:0] req;
        ev = '0;
        for (int c = 0; c < 3; c++) begin
            bit s;
            s = m_dl[c][SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_dl[c][i] = m_dl[c][i-1];
            m_dl[c][0] = raw[c];
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB + 1) begin
                    m_lvl[c]  = s;
                    m_run[c]  = 0;
                    m_hold[c] = 0;
                    ev[c]     = s;
                end
            end else begin
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                if (m_lvl[c] && m_run[c] == 0 && c != 2) begin
                    m_hold[c]++;
                    if (m_hold[c] >= RDLY && (m_hold[c] - RDLY) % RPER == 0) ev[c] = 1'b1;
                end
`endif
                m_run[c] = 0;
            end
        end
        req = m_pend | ev;
        if (req[2])      m_out = 3'b100;
        else if (req[1]) m_out = 3'b010;
        else if (req[0]) m_out = 3'b001;
        else             m_out = 3'b000;
        m_pend = req & ~m_out;
    endtask

    // One clock: drive at the falling edge, model the rising edge, return at the next fall.
    task automatic step(input logic [2:0] raw, input logic rst);
        bus.btn_right_raw = raw[0];
        bus.btn_left_raw  = raw[1];
        bus.btn_drop_raw  = raw[2];
        rst_n             = rst;
        @(posedge clk_25MHz);
        if (!rst) model_reset();
        else      model_edge(raw);
        @(negedge clk_25MHz);
    endtask

    function automatic logic [5:0] dut_vec();
        return {bus.drop_piece, bus.move_left, bus.move_right, bus.btn_state};
    endfunction

    function automatic logic [5:0] mdl_vec();
        return {m_out, m_lvl[2], m_lvl[1], m_lvl[0]};
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(3'b000, 1'b0);
            n_vec++;
            if (dut_vec() !== 6'b0) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %b, expected %b", k, dut_vec(), 6'b0);
            end
        end
        for (int k = 0; k < 8; k++) begin
            step(3'b000, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int npulse = 0;
        for (int k = 0; k < 45; k++) begin
            step((k < 30) ? 3'b010 : 3'b000, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL clean_press cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (bus.move_left) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        n_vec++;
        if (first != int'(SYNC + DEB) || npulse != 1) begin
            n_err++;
            $display("FAIL clean_press_latency: got edge %0d count %0d, expected edge %0d count 1",
                     first, npulse, SYNC + DEB);
        end
    endtask

    task automatic test_bounce();
        logic [2:0] raw;
        int seen = 0;
        for (int k = 0; k < 27; k++) begin
            raw = (k < 15 && (k % 3) != 2) ? 3'b001 : 3'b000;
            step(raw, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL bounce cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (dut_vec() != 6'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL bounce_quiet: got %0d active cycles, expected 0", seen);
        end
    endtask

    task automatic test_contention();
        int e_drop = -1;
        int e_left = -1;
        int e_right = -1;
        for (int k = 0; k < 34; k++) begin
            step((k < 20) ? 3'b111 : 3'b000, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec() || $countones(dut_vec() >> 3) > 1) begin
                n_err++;
                $display("FAIL contention cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (bus.drop_piece) e_drop = k;
            if (bus.move_left)  e_left = k;
            if (bus.move_right) e_right = k;
        end
        n_vec++;
        if (e_drop != 6 || e_left != 7 || e_right != 8) begin
            n_err++;
            $display("FAIL contention_order: got drop %0d left %0d right %0d, expected 6 7 8",
                     e_drop, e_left, e_right);
        end
    endtask

    task automatic test_reset_mid();
        int npulse = 0;
        int at = -1;
        for (int k = 0; k < 40; k++) begin
            step((k < 28) ? 3'b100 : 3'b000, (k == 3 || k == 4) ? 1'b0 : 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL reset_mid cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (bus.drop_piece) begin
                npulse++;
                at = k;
            end
        end
        // Reset is released before edge 5, which becomes the fresh press's edge 0.
        n_vec++;
        if (npulse != 1 || at != 5 + int'(SYNC + DEB)) begin
            n_err++;
            $display("FAIL reset_mid_pulse: got count %0d at %0d, expected count 1 at %0d",
                     npulse, at, 5 + SYNC + DEB);
        end
    endtask

    task automatic test_release_bounce();
        logic [2:0] raw;
        int npulse = 0;
        int dropped = 0;
        for (int k = 0; k < 44; k++) begin
            raw = (k < 30 && k != 12 && k != 13) ? 3'b010 : 3'b000;
            step(raw, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL release_bounce cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (bus.move_left) npulse++;
            if (k >= 6 && k < 30 && bus.btn_state != 3'b010) dropped++;
        end
        n_vec++;
        if (npulse != 1 || dropped != 0) begin
            n_err++;
            $display("FAIL release_bounce_hold: got %0d pulses %0d dropouts, expected 1 and 0",
                     npulse, dropped);
        end
    endtask

    task automatic test_random();
        logic [2:0] raw = '0;
        logic       rst;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 9) == 0) raw[c] = ~raw[c];
            end
            rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            step(raw, rst);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
        end
        for (int k = 0; k < 16; k++) begin
            step(3'b000, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL random_drain cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
        end
    endtask

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int exp_r [6] = '{6, 26, 34, 42, 50, 58};
        int got_r [$];
        int got_d [$];
        for (int k = 0; k < 72; k++) begin
            step((k < 60) ? 3'b001 : 3'b000, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL repeat_right cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (bus.move_right) got_r.push_back(k);
        end
        n_vec++;
        if (got_r.size() != 6 || got_r[0] != exp_r[0] || got_r[1] != exp_r[1] ||
            got_r[2] != exp_r[2] || got_r[5] != exp_r[5]) begin
            n_err++;
            $display("FAIL repeat_right_edges: got %p, expected %p", got_r, exp_r);
        end
        for (int k = 0; k < 72; k++) begin
            step((k < 60) ? 3'b100 : 3'b000, 1'b1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL repeat_drop cyc %0d: got %b, expected %b", k, dut_vec(), mdl_vec());
            end
            if (bus.drop_piece) got_d.push_back(k);
        end
        n_vec++;
        if (got_d.size() != 1 || got_d[0] != 6) begin
            n_err++;
            $display("FAIL repeat_drop_single: got %p, expected a single pulse at 6", got_d);
        end
    endtask
`endif

    initial begin
        bus.btn_right_raw = 1'b0;
        bus.btn_left_raw  = 1'b0;
        bus.btn_drop_raw  = 1'b0;
        model_reset();
        @(negedge clk_25MHz);
        test_reset();
        test_clean_press();
        test_bounce();
        test_contention();
        test_reset_mid();
        test_release_bounce();
        test_random();
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
